// File: rtl/sdc_reg_master.sv
// sdc_reg_master: Wishbone classic single-transfer register master.
// Optional bus timeout is compiled in with SDC_REG_MASTER_TIMEOUT_EN.
module sdc_reg_master #(
  parameter int AW             = 8,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [DW-1:0] cmd_dat_i,
  input  logic [3:0]    cmd_sel_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_dat_o,
  output logic          rsp_err_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  localparam logic [DW-1:0] TMO_DAT = DW'(32'hDEAD_BEEF);

  state_t state;
  state_t state_nxt;

  logic accept;
  logic ack;
  logic tmo;
  logic bus_done;
  logic rsp_done;

  assign accept   = (state == IDLE) && cmd_ready_o && cmd_valid_i;
  assign ack      = (state == BUS) && wb_ack_i;
  assign bus_done = ack || tmo;
  assign rsp_done = (state == RESP) && rsp_valid_o && rsp_ready_i;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      accept:   state_nxt = BUS;
      ack, tmo: state_nxt = RESP;
      rsp_done: state_nxt = IDLE;
      default:  state_nxt = state;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // cmd_ready is a flop so it stays low through reset and rises one edge later
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cmd_ready_o <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
    end else begin
      cmd_ready_o <= (state_nxt == IDLE);
      if (accept) begin
        wb_adr_o <= cmd_adr_i;
        wb_dat_o <= cmd_dat_i;
        wb_sel_o <= cmd_sel_i;
        wb_we_o  <= cmd_we_i;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end
      if (bus_done) begin
        wb_cyc_o    <= 1'b0;
        wb_stb_o    <= 1'b0;
        rsp_valid_o <= 1'b1;
        if (tmo) begin
          rsp_dat_o <= TMO_DAT;
        end else if (wb_we_o) begin
          rsp_dat_o <= '0;
        end else begin
          rsp_dat_o <= wb_dat_i;
        end
      end
      if (rsp_done) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

`ifdef SDC_REG_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  // the edge that would bring the count to TIMEOUT_CYCLES ends the cycle
  assign tmo = (state == BUS) && !wb_ack_i && (tmo_cnt == TMO_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        tmo_cnt <= '0;
      end else if ((state == BUS) && !wb_ack_i) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (bus_done) begin
        err_q <= tmo;
      end
    end
  end

  assign rsp_err_o = err_q;
`else
  logic unused_tmo;

  assign tmo        = 1'b0;
  assign rsp_err_o  = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_sdc_reg_master.sv
// tb_sdc_reg_master: randomized bench for sdc_reg_master against a
// memory-slave reference model; timeout cases need SDC_REG_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_sdc_reg_master;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [DW-1:0] cmd_dat_i = '0;
  logic [3:0]    cmd_sel_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;

  always #5 clk = ~clk;

  sdc_reg_master #(
    .AW(AW),
    .DW(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i),
    .cmd_dat_i(cmd_dat_i),
    .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  int total = 0;
  int bad = 0;

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] slv_mem [256];
  logic [DW-1:0] last_rsp = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  // lat = cycles cyc/stb stay high before the ack edge; 0 = never ack
  task automatic txn(input logic we, input logic [7:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input int lat, input int rdly);
    logic [31:0] exp_dat;
    logic        exp_err;
    int          n;
    chk("ready_pre", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    tick;
    cmd_valid_i = 1'b0;
    cmd_we_i    = ~we;
    cmd_adr_i   = ~adr;
    cmd_dat_i   = ~dat;
    n = (lat == 0) ? TMO : lat;
    for (int k = 1; k <= n; k++) begin
      chk("bus_hold",
          {wb_cyc_o, wb_stb_o, rsp_valid_o, wb_we_o, wb_sel_o,
           wb_adr_o, wb_dat_o},
          {2'b11, 1'b0, we, sel, adr, dat});
      chk("ready_bus", cmd_ready_o, 0);
      if (k == lat) begin
        wb_ack_i = 1'b1;
        if (wb_we_o) begin
          wb_dat_i = $urandom;
          slv_mem[wb_adr_o] = merge(slv_mem[wb_adr_o], wb_dat_o, wb_sel_o);
        end else begin
          wb_dat_i = slv_mem[wb_adr_o];
        end
      end
      tick;
      wb_ack_i = 1'b0;
    end
    if (lat == 0) begin
      exp_dat = 32'hDEAD_BEEF;
      exp_err = 1'b1;
    end else begin
      exp_dat = we ? 32'h0 : ref_mem[adr];
      exp_err = 1'b0;
      if (we) ref_mem[adr] = merge(ref_mem[adr], dat, sel);
    end
    last_rsp = exp_dat;
    chk("cyc_drop", {wb_cyc_o, wb_stb_o}, 0);
    chk("rsp_valid", rsp_valid_o, 1);
    chk("rsp_dat", rsp_dat_o, exp_dat);
    chk("rsp_err", rsp_err_o, exp_err);
    for (int k = 0; k < rdly; k++) begin
      tick;
      chk("bp_hold", {rsp_valid_o, rsp_err_o, cmd_ready_o, rsp_dat_o},
          {1'b1, exp_err, 1'b0, exp_dat});
    end
    rsp_ready_i = 1'b1;
    tick;
    rsp_ready_i = 1'b0;
    chk("rsp_done", {rsp_valid_o, cmd_ready_o}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[$];
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    ref_mem[8] = 32'hA5A5_5A5A;
    slv_mem[8] = 32'hA5A5_5A5A;

    #2 rst_n = 1'b0;
    tick;
    tick;
    chk("rst_ctrl",
        {cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o},
        0);
    chk("rst_data", {wb_adr_o, wb_sel_o, wb_dat_o}, 0);
    chk("rst_rdat", rsp_dat_o, 0);
    rst_n = 1'b1;
    tick;
    chk("ready_after_rst", cmd_ready_o, 1);

    txn(1'b1, 8'h04, 32'h0000_0123, 4'hF, 1, 0);
    txn(1'b0, 8'h08, 32'h0, 4'hF, 3, 0);
    txn(1'b0, 8'h04, 32'h0, 4'hF, 2, 10);

    // back-to-back reads with cmd_valid held high
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 8'h08;
    cmd_sel_i   = 4'hF;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready_o) acc.push_back(i);
      if (rsp_valid_o) chk("b2b_dat", rsp_dat_o, 32'hA5A5_5A5A);
      wb_ack_i = wb_cyc_o;
      wb_dat_i = slv_mem[8];
      tick;
    end
    cmd_valid_i = 1'b0;
    wb_ack_i    = 1'b0;
    rsp_ready_i = 1'b0;
    last_rsp    = 32'hA5A5_5A5A;
    chk("b2b_count", acc.size(), 4);
    for (int j = 0; j + 1 < acc.size(); j++)
      chk("b2b_gap", acc[j+1] - acc[j], 3);

    // spurious ack while idle
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1357_9BDF;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("spur_ack", {wb_cyc_o, rsp_valid_o, cmd_ready_o, rsp_dat_o},
          {2'b00, 1'b1, last_rsp});
    end
    wb_ack_i = 1'b0;

    // reset during BUS
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 8'h08;
    tick;
    cmd_valid_i = 1'b0;
    chk("abort_cyc", wb_cyc_o, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_async", {wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o}, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("abort_post", {wb_cyc_o, rsp_valid_o, cmd_ready_o}, 3'b001);
    tick;
    chk("abort_norsp", rsp_valid_o, 0);
    txn(1'b0, 8'h08, 32'h0, 4'hF, 2, 1);

`ifdef SDC_REG_MASTER_TIMEOUT_EN
    txn(1'b0, 8'h08, 32'h0, 4'hF, 0, 2);
    txn(1'b0, 8'h08, 32'h0, 4'hF, TMO, 0);
`else
    txn(1'b0, 8'h08, 32'h0, 4'hF, TMO + 24, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
          4'($urandom_range(0, 15)), $urandom_range(1, 5),
          $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdc_reg_master.md
SDC_REG_MASTER -- requirements
Module: sdc_reg_master

Interface
REQ-001 Parameter AW, default 8, Wishbone address width (matches the sdc_controller slave register port).
REQ-002 Parameter DW, default 32, Wishbone data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, maximum cycles in BUS awaiting ack (only used when timeout is compiled in).
REQ-004 Ports, one per line (name, direction, width, meaning):
  wb_clk_i  in  1  the block's single clock; all logic is clocked on its rising edge.
  wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
  cmd_valid_i  in  1  command request.
  cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
  cmd_we_i  in  1  1 = write, 0 = read.
  cmd_adr_i  in  AW  register address.
  cmd_dat_i  in  DW  write data.
  cmd_sel_i  in  4  byte enables.
  rsp_valid_o  out  1  response available.
  rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
  rsp_dat_o  out  DW  read data; 0 for writes.
  rsp_err_o  out  1  transaction timed out.
  wb_adr_o  out  AW  Wishbone address.
  wb_dat_o  out  DW  Wishbone write data.
  wb_sel_o  out  4  Wishbone byte select.
  wb_we_o  out  1  Wishbone write enable.
  wb_cyc_o  out  1  Wishbone cycle.
  wb_stb_o  out  1  Wishbone strobe.
  wb_dat_i  in  DW  Wishbone read data.
  wb_ack_i  in  1  Wishbone acknowledge from the addressed slave.

Function
REQ-005 Wishbone classic single read/write master; no bursts (no cti/bte); one outstanding transaction.
REQ-006 FSM states: IDLE, BUS, RESP; all Wishbone and rsp_* outputs are registered.
REQ-007 IDLE: cmd_ready_o=1; on cmd_valid_i&cmd_ready_o, latch we/adr/dat/sel and go to BUS; wb_cyc_o/wb_stb_o go high in the cycle after acceptance.
REQ-008 BUS: cmd_ready_o=0; cyc, stb, adr, dat, sel, we held stable until wb_ack_i is sampled high.
REQ-009 Ack in BUS: capture wb_dat_i into rsp_dat_o (read) or load 0 (write), rsp_err_o=0, deassert cyc/stb on the next edge, go to RESP.
REQ-010 RESP: rsp_valid_o=1 with rsp_dat_o/rsp_err_o stable until rsp_ready_i; on handshake, rsp_valid_o=0 and go to IDLE.
REQ-011 Minimum latency: accept at edge N, stb high from N+1, ack sampled at N+1, rsp_valid_o high from N+2, next accept no earlier than N+3.
REQ-012 wb_ack_i sampled outside BUS is ignored and changes no state.
REQ-013 cmd_valid_i outside IDLE is not accepted and has no effect.
REQ-014 wb_dat_o/wb_adr_o/wb_sel_o/wb_we_o keep their last values when cyc is low; slaves shall not rely on them.

Reset
REQ-015 wb_rst_n_i low asynchronously forces IDLE; wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o = 0; wb_adr_o, wb_dat_o, wb_sel_o, rsp_dat_o = 0; timeout counter = 0.
REQ-016 cmd_ready_o is 0 while reset is asserted and 1 from the first edge after release.
REQ-017 Reset asserted mid-BUS drops cyc/stb immediately; no response is produced for the aborted transaction.

Configuration
REQ-018 Macro SDC_REG_MASTER_TIMEOUT_EN defined: counter, width $clog2(TIMEOUT_CYCLES+1), cleared on entry to BUS and incremented each BUS cycle without ack.
REQ-019 With the macro, when the counter reaches TIMEOUT_CYCLES without ack: cyc/stb deassert, rsp_err_o=1, rsp_dat_o=32'hDEAD_BEEF, go to RESP.
REQ-020 With the macro, ack sampled in the same cycle the counter reaches TIMEOUT_CYCLES wins: normal response, rsp_err_o=0.
REQ-021 Without the macro: no counter; BUS waits indefinitely for ack; rsp_err_o is constant 0.

Verification
REQ-022 Write: cmd we=1, adr=8'h04, dat=32'h0000_0123, sel=4'hF; slave acks 1 cycle after stb -> one write cycle with those values, rsp_valid_o with rsp_dat_o=0, rsp_err_o=0.
REQ-023 Read: adr=8'h08, slave acks 3 cycles after stb with 32'hA5A5_5A5A -> rsp_dat_o=32'hA5A5_5A5A; cyc/stb high exactly 3 cycles.
REQ-024 Backpressure: rsp_ready_i held 0 for 10 cycles -> rsp_valid_o and rsp_dat_o stable; cmd_ready_o=0 until the handshake.
REQ-025 Timeout (macro on, TIMEOUT_CYCLES=16): no ack -> cyc low after 16 BUS cycles, rsp_err_o=1, rsp_dat_o=32'hDEAD_BEEF; ack on cycle 16 -> rsp_err_o=0.
REQ-026 Reset mid-BUS: wb_rst_n_i low for 1 cycle -> cyc/stb fall asynchronously, no rsp_valid_o, next command completes normally.
REQ-027 Spurious wb_ack_i in IDLE, plus back-to-back commands with cmd_valid_i held high -> no state change from the spurious ack; commands are accepted every 3 cycles.
